fsm_alu_param: RTL and testbench

//  Parametrised successor of the go-triggered FSM ALU: WIDTH-bit operands, 8 operations.

---
 rtl/fsm_alu_param.sv | 167 ++++++++++++++++
 tb/tb_fsm_alu_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fsm_alu_param.sv
// Go-triggered FSM ALU with WIDTH-bit operands, shift-add multiplier and zero flag.
// Optional chained operation from the previous result is enabled by defining ALU_ACCUM_EN.
module fsm_alu_param #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [2:0]           opcode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   result,
   output logic                 cout,
   output logic                 zero,
   output logic                 led_idle,
   output logic                 led_ready,
   output logic                 led_done
);

   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned SW = $clog2(WIDTH) + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StReady = 2'd1;
   localparam logic [1:0] StExec  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpNot = 3'd5;
   localparam logic [2:0] OpMul = 3'd6;
   localparam logic [2:0] OpShl = 3'd7;

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [RW-1:0]    prod_q, prod_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]    result_q, result_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] a_sel;
   logic [WIDTH:0]   sum, diff, shl_ext;
   logic [SW-1:0]    sh;
   logic [RW-1:0]    alu_res, pp, prod_nxt;
   logic             alu_cout;

`ifdef ALU_ACCUM_EN
   // Chained calculation: from READY the previous low result half replaces port a.
   assign a_sel = (state_q == StReady) ? result_q[WIDTH-1:0] : a;
`else
   assign a_sel = a;
`endif

   assign sum      = {1'b0, a_q} + {1'b0, b_q};
   assign diff     = {1'b0, a_q} - {1'b0, b_q};
   assign sh       = b_q[SW-1:0];
   // Bit WIDTH of the extended shift is the last bit pushed out; zero for sh==0 or sh>WIDTH.
   assign shl_ext  = {1'b0, a_q} << sh;
   assign pp       = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
   assign prod_nxt = prod_q + pp;

   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      case (op_q)
         OpAdd: begin
            alu_res  = {{(WIDTH-1){1'b0}}, sum};
            alu_cout = sum[WIDTH];
         end
         OpSub: begin
            alu_res  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            alu_cout = diff[WIDTH];
         end
         OpAnd: alu_res = {{WIDTH{1'b0}}, a_q & b_q};
         OpOr:  alu_res = {{WIDTH{1'b0}}, a_q | b_q};
         OpXor: alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
         OpNot: alu_res = {{WIDTH{1'b0}}, ~a_q};
         OpShl: begin
            alu_res  = {{WIDTH{1'b0}}, shl_ext[WIDTH-1:0]};
            alu_cout = shl_ext[WIDTH];
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      unique case (state_q)
         StIdle, StReady: begin
            if (go) begin
               op_d    = opcode;
               a_d     = a_sel;
               b_d     = b;
               prod_d  = '0;
               cnt_d   = '0;
               state_d = StExec;
            end
         end
         StExec: begin
            if (op_q == OpMul) begin
               prod_d = prod_nxt;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  result_d = prod_nxt;
                  cout_d   = 1'b0;
                  zero_d   = (prod_nxt == '0);
                  state_d  = StDone;
               end
            end else begin
               result_d = alu_res;
               cout_d   = alu_cout;
               zero_d   = (alu_res == '0);
               state_d  = StDone;
            end
         end
         StDone: begin
            if (!go) state_d = StReady;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
      end
   end

   assign result    = result_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign led_idle  = (state_q == StIdle);
   assign led_ready = (state_q == StReady);
   assign led_done  = (state_q == StDone);

endmodule

// File: tb/tb_fsm_alu_param.sv
// Scoreboard bench for fsm_alu_param: driver pushes model results, monitor checks on DONE entry.
module tb_fsm_alu_param;
   localparam int W = 4;
   localparam int MASK = (1 << W) - 1;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           go = 1'b0;
   logic [2:0]     opcode = '0;
   logic [W-1:0]   a = '0, b = '0;
   logic [2*W-1:0] result;
   logic           cout, zero, led_idle, led_ready, led_done;

   fsm_alu_param #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .go(go), .opcode(opcode), .a(a), .b(b),
      .result(result), .cout(cout), .zero(zero),
      .led_idle(led_idle), .led_ready(led_ready), .led_done(led_done)
   );

   always #5 clk = ~clk;

   typedef struct {int res; int co; int z; int lat; int gc;} exp_t;
   exp_t q[$];
   int   total = 0, bad = 0, cyc = 0;
   int   acc = 0;
   bit   from_ready = 0;
   bit   prev_done = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic void model(input int av, input int bv, input int op,
                                 output int res, output int co);
      int sh;
      co = 0;
      case (op)
         0: begin res = av + bv; co = (res > MASK) ? 1 : 0; end
         1: begin res = (av - bv) & MASK; co = (av < bv) ? 1 : 0; end
         2: res = av & bv;
         3: res = av | bv;
         4: res = av ^ bv;
         5: res = (~av) & MASK;
         6: res = av * bv;
         default: begin
            sh  = bv & ((2 << $clog2(W)) - 1);
            res = (av << sh) & MASK;
            if (sh >= 1 && sh <= W) co = (av >> (W - sh)) & 1;
         end
      endcase
   endfunction

   // Monitor: every entry into DONE consumes one expected transaction.
   always @(negedge clk) begin
      exp_t e;
      if (led_done && !prev_done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("result", int'(result), e.res);
            chk("cout", int'(cout), e.co);
            chk("zero", int'(zero), e.z);
            chk("latency", cyc - e.gc, e.lat);
         end
      end
      prev_done = led_done;
   end

   task automatic issue(input int av, input int bv, input int op, input int hold);
      exp_t e;
      int   aeff;
      int   n;
`ifdef ALU_ACCUM_EN
      aeff = from_ready ? (acc & MASK) : av;
`else
      aeff = av;
`endif
      model(aeff, bv, op, e.res, e.co);
      e.z   = (e.res == 0) ? 1 : 0;
      e.lat = (op == 6) ? W : 1;
      @(negedge clk);
      a = W'(av); b = W'(bv); opcode = 3'(op); go = 1'b1;
      e.gc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); opcode = 3'($urandom);
      repeat (hold) @(negedge clk);
      if (hold > e.lat + 1) chk("done_hold", int'(led_done), 1);
      go = 1'b0;
      n = 0;
      while (!led_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("back_to_ready", int'(led_ready), 1);
      acc = e.res;
      from_ready = 1;
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_idle", int'(led_idle), 1);
      chk("rst_result", int'(result), 0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_cout", int'(cout), 0);
      chk("rst_done", int'(led_done), 0);
      reset = 1'b1;

      issue(9, 9, 0, 0);
      issue(9, 9, 1, 1);
      issue(3, 5, 1, 0);
      issue(15, 15, 6, 7);
      issue(5, 4, 7, 0);
      issue(12, 2, 7, 0);
      issue(10, 0, 7, 0);
      issue(9, 6, 7, 0);
      issue(0, 7, 6, 2);
      for (int i = 0; i < 40; i++)
         issue($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 7),
               $urandom_range(0, 6));

      // Reset abandons a multiply in progress.
      @(negedge clk);
      a = 4'd15; b = 4'd15; opcode = 3'd6; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("midmul_idle", int'(led_idle), 1);
      chk("midmul_result", int'(result), 0);
      chk("midmul_zero", int'(zero), 1);
      from_ready = 0;
      acc = 0;
      issue(3, 4, 0, 0);
      issue(11, 2, 0, 0);

      repeat (W + 3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
